// File: rtl/fwd_pkg.sv
// fwd_pkg
//   Shared types and constants for the forwarding / hazard unit.
//   - tag_t      : one in-flight producer descriptor {valid, reg_write, is_load, rd}
//   - FWD_SEL_RF : forward-select value meaning "take the register file"
//   - calc_sel_w : width of a single forward-select field for a given
//                  number of forward sources
//   The rd field is sized for the widest supported register number
//   (TAG_RD_W bits); narrower register numbers are zero-extended into it.
package fwd_pkg;

  localparam int TAG_RD_W   = 8;
  localparam int FWD_SEL_RF = 0;

  typedef struct packed {
    logic                valid;
    logic                reg_write;
    logic                is_load;
    logic [TAG_RD_W-1:0] rd;
  } tag_t;

  // Select width must encode 0 (register file) plus FWD_STAGES sources.
  function automatic int calc_sel_w(input int stages);
    return (stages < 1) ? 1 : $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/fwd_match_encoder.sv
// fwd_match_encoder
//   Combinational per-operand matcher. Scans the destination-tag pipeline
//   from youngest (tag 0) to oldest and reports the forward source for one
//   source register.
// Ports:
//   rs_i           in   REG_W       source register number
//   tags_i         in   tag_t[FWD_STAGES]  in-flight producer tags, 0 = EX
//   sel_o          out  SEL_W       candidate select, 0 = register file
//   load_use_hit_o out  1           youngest match is a load whose data is
//                                   not yet available at its stage
//   any_match_o    out  1           any stage matches (used when forwarding
//                                   is disabled)
module fwd_match_encoder
  import fwd_pkg::*;
#(
  parameter int REG_W      = 4,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_SRC   = 2,
  parameter int SEL_W      = 2
) (
  input  logic [REG_W-1:0] rs_i,
  input  tag_t             tags_i [FWD_STAGES],
  output logic [SEL_W-1:0] sel_o,
  output logic             load_use_hit_o,
  output logic             any_match_o
);

  logic [TAG_RD_W-1:0] rsExt;
  assign rsExt = TAG_RD_W'(rs_i);

  // Priority scan: the first (youngest) matching stage wins the select and
  // decides whether this is a load-use hazard; any match at all is also
  // flagged for the no-forwarding mode.
  always_comb begin
    logic found;
    logic match;
    found          = 1'b0;
    match          = 1'b0;
    sel_o          = SEL_W'(FWD_SEL_RF);
    load_use_hit_o = 1'b0;
    any_match_o    = 1'b0;
    for (int j = 0; j < FWD_STAGES; j++) begin
      match = tags_i[j].valid && tags_i[j].reg_write &&
              (tags_i[j].rd != '0) && (tags_i[j].rd == rsExt);
      if (match) begin
        any_match_o = 1'b1;
        if (!found) begin
          found          = 1'b1;
          sel_o          = SEL_W'(j + 1);
          load_use_hit_o = tags_i[j].is_load && ((j + 1) < LOAD_SRC);
        end
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//   Forwarding and hazard unit sitting beside the ID/EX boundary. It tracks
//   in-flight producers in its own tag pipeline, registers a forward select
//   for each operand of the instruction entering EX, raises load-use and
//   no-forward-mode stalls, and counts stall cycles (saturating).
// Ports:
//   clk           in   1                clock
//   rst_n         in   1                synchronous active-low reset
//   id_valid      in   1                ID holds a real instruction
//   id_rs         in   NUM_SRC*REG_W    source registers, operand i at [i*REG_W +: REG_W]
//   id_rd         in   REG_W            destination register of ID instruction
//   id_reg_write  in   1                ID instruction writes id_rd
//   id_is_load    in   1                ID instruction is a load
//   ex_flush      in   1                kill ID and EX instructions
//   fwd_disable   in   1                1 = no forwarding, stall on every RAW
//   stall         out  1                hold IF/ID, bubble into EX (combinational)
//   fwd_sel       out  NUM_SRC*SEL_W    per-operand select for the EX instruction
//   stall_count   out  CNT_W            saturating stall-cycle count
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_W      = 4,
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_SRC   = 2,
  parameter int CNT_W      = 16,
  parameter int SEL_W      = calc_sel_w(FWD_STAGES)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       id_valid,
  input  logic [NUM_SRC*REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]           id_rd,
  input  logic                       id_reg_write,
  input  logic                       id_is_load,
  input  logic                       ex_flush,
  input  logic                       fwd_disable,
  output logic                       stall,
  output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
  output logic [CNT_W-1:0]           stall_count
);

  tag_t                     tag_q [FWD_STAGES];
  tag_t                     tag_d [FWD_STAGES];
  tag_t                     idTag;
  logic [SEL_W-1:0]         candSel [NUM_SRC];
  logic [NUM_SRC-1:0]       hitVec;
  logic [NUM_SRC-1:0]       anyVec;
  logic                     advance;
  logic [NUM_SRC*SEL_W-1:0] fwdSel_q;
  logic [NUM_SRC*SEL_W-1:0] fwdSel_d;
  logic [CNT_W-1:0]         stallCount_q;
  logic [CNT_W-1:0]         stallCount_d;

  assign idTag = '{valid:     id_valid,
                   reg_write: id_reg_write,
                   is_load:   id_is_load,
                   rd:        TAG_RD_W'(id_rd)};

  // One matcher per source operand, all looking at the same tag pipeline.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_match_encoder #(
      .REG_W      (REG_W),
      .FWD_STAGES (FWD_STAGES),
      .LOAD_SRC   (LOAD_SRC),
      .SEL_W      (SEL_W)
    ) u_enc (
      .rs_i           (id_rs[i*REG_W +: REG_W]),
      .tags_i         (tag_q),
      .sel_o          (candSel[i]),
      .load_use_hit_o (hitVec[i]),
      .any_match_o    (anyVec[i])
    );
  end

  // In no-forward mode any RAW on an in-flight producer stalls until the
  // producer has left the pipeline; otherwise only a too-young load does.
  assign stall   = id_valid && (fwd_disable ? (|anyVec) : (|hitVec));
  assign advance = id_valid && !stall && !ex_flush;

  // The back end never stalls, so tags shift every cycle; the youngest slot
  // takes the ID instruction only when it actually issues into EX.
  always_comb begin
    tag_d[0] = advance ? idTag : '0;
    for (int j = 1; j < FWD_STAGES; j++) begin
      tag_d[j] = tag_q[j-1];
    end
  end

  // Selects follow the instruction into EX; bubbles, flushes and the
  // no-forward mode all fall back to the register file.
  always_comb begin
    fwdSel_d = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      fwdSel_d[i*SEL_W +: SEL_W] = (advance && !fwd_disable) ? candSel[i]
                                                             : SEL_W'(FWD_SEL_RF);
    end
  end

  // Stall counter sticks at all-ones instead of wrapping.
  always_comb begin
    stallCount_d = stallCount_q;
    if (stall && (stallCount_q != '1)) begin
      stallCount_d = stallCount_q + 1'b1;
    end
  end

  // All state clears on reset so that stall drops immediately afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < FWD_STAGES; j++) begin
        tag_q[j] <= '0;
      end
      fwdSel_q     <= '0;
      stallCount_q <= '0;
    end else begin
      for (int j = 0; j < FWD_STAGES; j++) begin
        tag_q[j] <= tag_d[j];
      end
      fwdSel_q     <= fwdSel_d;
      stallCount_q <= stallCount_d;
    end
  end

  assign fwd_sel     = fwdSel_q;
  assign stall_count = stallCount_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit
//   Directed bench for fwd_hazard_unit with default parameters. Inputs are
//   driven 1 time unit after the rising edge, outputs are sampled 1 unit
//   later, well away from the next edge.
module tb_fwd_hazard_unit;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [7:0]  id_rs;
  logic [3:0]  id_rd;
  logic        id_reg_write;
  logic        id_is_load;
  logic        ex_flush;
  logic        fwd_disable;
  logic        stall;
  logic [3:0]  fwd_sel;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;

  fwd_hazard_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_is_load   (id_is_load),
    .ex_flush     (ex_flush),
    .fwd_disable  (fwd_disable),
    .stall        (stall),
    .fwd_sel      (fwd_sel),
    .stall_count  (stall_count)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one ID-stage instruction (or a bubble with valid=0) and let the
  // combinational stall settle.
  task automatic applyStimulus(input logic v, input logic [3:0] rs0,
                               input logic [3:0] rs1, input logic [3:0] rd,
                               input logic we, input logic ld,
                               input logic flush);
    id_valid     = v;
    id_rs        = {rs1, rs0};
    id_rd        = rd;
    id_reg_write = we;
    id_is_load   = ld;
    ex_flush     = flush;
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      $error("[TB] check %s", tag);
    end
  endtask

  // Let the two tag stages drain so the next scenario starts clean.
  task automatic drain();
    idle();
    tick();
    tick();
  endtask

  initial begin
    rst_n       = 1'b0;
    fwd_disable = 1'b0;
    idle();
    tick();
    tick();
    checkOutput("reset_stall", 32'(stall), 32'd0);
    checkOutput("reset_sel", 32'(fwd_sel), 32'd0);
    checkOutput("reset_cnt", 32'(stall_count), 32'd0);
    rst_n = 1'b1;

    // 1: ALU producer then immediate consumer -> EX/MEM forward on op0.
    applyStimulus(1'b1, 4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 4'd3, 4'd0, 4'd6, 1'b1, 1'b0, 1'b0);
    checkOutput("t1_stall", 32'(stall), 32'd0);
    tick();
    checkOutput("t1_sel", 32'(fwd_sel), 32'h1);
    drain();

    // 2: producer, bubble, consumer on op1 -> MEM/WB forward on op1 only.
    applyStimulus(1'b1, 4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    applyStimulus(1'b1, 4'd7, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("t2_stall", 32'(stall), 32'd0);
    tick();
    checkOutput("t2_sel", 32'(fwd_sel), 32'h8);
    drain();

    // 3: two producers of r5 back to back -> youngest (source 1) wins.
    applyStimulus(1'b1, 4'd0, 4'd0, 4'd5, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 4'd0, 4'd0, 4'd5, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 4'd5, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("t3_sel", 32'(fwd_sel), 32'h5);
    drain();

    // 4: load then immediate consumer -> one stall cycle, then source 2.
    applyStimulus(1'b1, 4'd0, 4'd0, 4'd4, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 4'd4, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("t4_stall_on", 32'(stall), 32'd1);
    tick();
    checkOutput("t4_bubble_sel", 32'(fwd_sel), 32'h0);
    checkOutput("t4_stall_off", 32'(stall), 32'd0);
    checkOutput("t4_cnt", 32'(stall_count), 32'd1);
    tick();
    checkOutput("t4_sel", 32'(fwd_sel), 32'h2);
    checkOutput("t4_cnt_hold", 32'(stall_count), 32'd1);
    drain();

    // 5a: register 0 is never forwarded.
    applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_r0_stall", 32'(stall), 32'd0);
    tick();
    checkOutput("t5_r0_sel", 32'(fwd_sel), 32'h0);
    drain();

    // 5b: no-forward mode, fresh counter -> two stall cycles, select 0.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    fwd_disable = 1'b1;
    applyStimulus(1'b1, 4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_nf_stall1", 32'(stall), 32'd1);
    tick();
    checkOutput("t5_nf_stall2", 32'(stall), 32'd1);
    checkOutput("t5_nf_sel_mid", 32'(fwd_sel), 32'h0);
    tick();
    checkOutput("t5_nf_stall_end", 32'(stall), 32'd0);
    tick();
    checkOutput("t5_nf_sel", 32'(fwd_sel), 32'h0);
    checkOutput("t5_nf_cnt", 32'(stall_count), 32'd2);
    fwd_disable = 1'b0;
    drain();

    // 6a: flush during a load-use stall. The flushed ID instruction writes
    // r9; a follow-up reader of r9 must not see it, but still sees the load.
    applyStimulus(1'b1, 4'd0, 4'd0, 4'd4, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 4'd4, 4'd0, 4'd9, 1'b1, 1'b0, 1'b1);
    checkOutput("t6_flush_stall", 32'(stall), 32'd1);
    tick();
    checkOutput("t6_flush_sel", 32'(fwd_sel), 32'h0);
    checkOutput("t6_flush_cnt", 32'(stall_count), 32'd3);
    applyStimulus(1'b1, 4'd9, 4'd4, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("t6_after_stall", 32'(stall), 32'd0);
    tick();
    checkOutput("t6_after_sel", 32'(fwd_sel), 32'h8);
    drain();

    // 6b: reset mid-stall drops everything, including the in-flight load.
    applyStimulus(1'b1, 4'd0, 4'd0, 4'd4, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 4'd4, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("t6_rst_pre", 32'(stall), 32'd1);
    rst_n = 1'b0;
    tick();
    checkOutput("t6_rst_stall", 32'(stall), 32'd0);
    checkOutput("t6_rst_sel", 32'(fwd_sel), 32'h0);
    checkOutput("t6_rst_cnt", 32'(stall_count), 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("t6_rst_issue_sel", 32'(fwd_sel), 32'h0);
    checkOutput("t6_rst_issue_cnt", 32'(stall_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
